// File: rtl/memory_turn_ctrl_if.sv
// Selector/board-side bundle for the memory-game turn sequencer.
// The master side is the selector and board; the slave side is the sequencer.
interface memory_turn_ctrl_if;
   logic       start;
   logic       select;
   logic [3:0] sel_idx;
   logic [3:0] card_val;
   logic       slot_avail;
   logic       player;
   logic [3:0] reveal_a;
   logic [3:0] reveal_b;
   logic [1:0] reveal_en;
   logic       clear_we;
   logic [3:0] clear_idx;
   logic       match;
   logic       timeout;
   logic [7:0] score0;
   logic [7:0] score1;
   logic       game_over;
   logic [1:0] winner;

   modport master (
      output start, select, sel_idx, card_val, slot_avail,
      input  player, reveal_a, reveal_b, reveal_en, clear_we, clear_idx,
      input  match, timeout, score0, score1, game_over, winner
   );

   modport slave (
      input  start, select, sel_idx, card_val, slot_avail,
      output player, reveal_a, reveal_b, reveal_en, clear_we, clear_idx,
      output match, timeout, score0, score1, game_over, winner
   );
endinterface

// File: rtl/memory_turn_ctrl.sv
// Two-player memory-game turn sequencer: accepted 2nd pick -> match pulse +1 cycle, clears at +2/+3.
// No backpressure: selects outside PICK1/PICK2 or failing the pick rules are dropped.
module memory_turn_ctrl #(
   parameter int NUM_CARDS    = 16,
   parameter int SHOW_CYCLES  = 50,
   parameter int TURN_TIMEOUT = 1000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   memory_turn_ctrl_if.slave bus
);
   localparam int TW = $clog2(TURN_TIMEOUT);
   localparam int SW = $clog2(SHOW_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_TIMEOUT - 1);
   localparam logic [SW-1:0] SHOW_LOAD  = SW'(SHOW_CYCLES - 1);
   localparam logic [4:0]    SLOT_LIMIT = 5'(NUM_CARDS);
   localparam logic [3:0]    PAIRS_INIT = 4'(NUM_CARDS / 2);

   typedef enum logic [2:0] {
      S_IDLE, S_PICK1, S_PICK2, S_COMPARE, S_SHOW, S_CLEAR1, S_CLEAR2, S_DONE
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [SW-1:0] r_show_cnt;
   logic [3:0]    r_pairs_left;
   logic [3:0]    r_idx_a, r_idx_b, r_val_a, r_val_b;
   logic          r_player, r_clear_we, r_match, r_timeout, r_game_over;
   logic [1:0]    r_reveal_en, r_winner;
   logic [3:0]    r_clear_idx;
   logic [7:0]    r_score0, r_score1;

   logic       w_sel_ok, w_expire;
   logic [1:0] w_winner;

   assign w_sel_ok = bus.select && bus.slot_avail && ({1'b0, bus.sel_idx} < SLOT_LIMIT);
   assign w_expire = (r_timer == TIMER_LAST);
   assign w_winner = (r_score0 > r_score1) ? 2'b01 :
                     (r_score1 > r_score0) ? 2'b10 : 2'b11;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_timer      <= '0;
         r_show_cnt   <= '0;
         r_pairs_left <= '0;
         r_idx_a      <= '0;
         r_idx_b      <= '0;
         r_val_a      <= '0;
         r_val_b      <= '0;
         r_player     <= 1'b0;
         r_clear_we   <= 1'b0;
         r_clear_idx  <= '0;
         r_match      <= 1'b0;
         r_timeout    <= 1'b0;
         r_game_over  <= 1'b0;
         r_reveal_en  <= '0;
         r_winner     <= '0;
         r_score0     <= '0;
         r_score1     <= '0;
      end else begin
         r_match    <= 1'b0;
         r_timeout  <= 1'b0;
         r_clear_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_player     <= 1'b0;
                  r_score0     <= '0;
                  r_score1     <= '0;
                  r_pairs_left <= PAIRS_INIT;
                  r_timer      <= '0;
                  r_reveal_en  <= '0;
                  r_game_over  <= 1'b0;
                  r_winner     <= '0;
                  r_state      <= S_PICK1;
               end
            end
            S_PICK1: begin
               if (w_sel_ok) begin
                  r_idx_a     <= bus.sel_idx;
                  r_val_a     <= bus.card_val;
                  r_reveal_en <= 2'b01;
                  r_timer     <= '0;
                  r_state     <= S_PICK2;
               end else if (w_expire) begin
                  r_timeout   <= 1'b1;
                  r_reveal_en <= '0;
                  r_player    <= ~r_player;
                  r_timer     <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_PICK2: begin
               if (w_sel_ok && (bus.sel_idx != r_idx_a)) begin
                  r_idx_b     <= bus.sel_idx;
                  r_val_b     <= bus.card_val;
                  r_reveal_en <= 2'b11;
                  r_match     <= (bus.card_val == r_val_a);
                  r_state     <= S_COMPARE;
               end else if (w_expire) begin
                  r_timeout   <= 1'b1;
                  r_reveal_en <= '0;
                  r_player    <= ~r_player;
                  r_timer     <= '0;
                  r_state     <= S_PICK1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_COMPARE: begin
               // r_match was computed from the same two values latched in PICK1/PICK2
               if (r_match) begin
                  if (!r_player && r_score0 != 8'hFF) r_score0 <= r_score0 + 8'd1;
                  if (r_player && r_score1 != 8'hFF)  r_score1 <= r_score1 + 8'd1;
                  r_pairs_left <= r_pairs_left - 4'd1;
                  r_clear_we   <= 1'b1;
                  r_clear_idx  <= r_idx_a;
                  r_state      <= S_CLEAR1;
               end else begin
                  r_show_cnt <= SHOW_LOAD;
                  r_state    <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (r_show_cnt == '0) begin
                  r_reveal_en <= '0;
                  r_player    <= ~r_player;
                  r_timer     <= '0;
                  r_state     <= S_PICK1;
               end else begin
                  r_show_cnt <= r_show_cnt - 1'b1;
               end
            end
            S_CLEAR1: begin
               r_clear_we  <= 1'b1;
               r_clear_idx <= r_idx_b;
               r_state     <= S_CLEAR2;
            end
            S_CLEAR2: begin
               r_reveal_en <= '0;
               r_timer     <= '0;
               if (r_pairs_left == '0) begin
                  r_game_over <= 1'b1;
                  r_winner    <= w_winner;
                  r_state     <= S_DONE;
               end else begin
                  r_state <= S_PICK1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.player    = r_player;
   assign bus.reveal_a  = r_idx_a;
   assign bus.reveal_b  = r_idx_b;
   assign bus.reveal_en = r_reveal_en;
   assign bus.clear_we  = r_clear_we;
   assign bus.clear_idx = r_clear_idx;
   assign bus.match     = r_match;
   assign bus.timeout   = r_timeout;
   assign bus.score0    = r_score0;
   assign bus.score1    = r_score1;
   assign bus.game_over = r_game_over;
   assign bus.winner    = r_winner;
endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: scripted games plus random games against a game-level model.
module tb_memory_turn_ctrl;
   localparam int NUM_CARDS    = 16;
   localparam int SHOW_CYCLES  = 50;
   localparam int TURN_TIMEOUT = 1000;

   logic clk;
   logic rst;
   memory_turn_ctrl_if bus();

   logic [3:0] brd_val [16];
   logic       brd_av  [16];
   int n_chk = 0;
   int n_err = 0;
   int exp_player;
   int exp_s [2];
   int pairs_left;

   memory_turn_ctrl #(
      .NUM_CARDS(NUM_CARDS), .SHOW_CYCLES(SHOW_CYCLES), .TURN_TIMEOUT(TURN_TIMEOUT)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   assign bus.card_val   = brd_val[bus.sel_idx];
   assign bus.slot_avail = brd_av[bus.sel_idx];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic pick(input int idx);
      bus.select  = 1'b1;
      bus.sel_idx = 4'(idx);
      step();
      bus.select  = 1'b0;
   endtask

   function automatic int exp_winner();
      if (exp_s[0] > exp_s[1]) return 1;
      if (exp_s[1] > exp_s[0]) return 2;
      return 3;
   endfunction

   task automatic new_game_model();
      exp_player = 0;
      exp_s[0]   = 0;
      exp_s[1]   = 0;
      pairs_left = NUM_CARDS / 2;
      for (int i = 0; i < 16; i++) brd_av[i] = 1'b1;
   endtask

   task automatic check_fresh(input string tag);
      check({tag, "_player"},    int'(bus.player), 0);
      check({tag, "_score0"},    int'(bus.score0), 0);
      check({tag, "_score1"},    int'(bus.score1), 0);
      check({tag, "_reveal_en"}, int'(bus.reveal_en), 0);
      check({tag, "_game_over"}, int'(bus.game_over), 0);
      check({tag, "_winner"},    int'(bus.winner), 0);
      check({tag, "_clear_we"},  int'(bus.clear_we), 0);
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      new_game_model();
      check_fresh("start");
   endtask

   task automatic set_directed_board();
      int pa [8] = '{2, 3, 4, 0, 5, 10, 12, 14};
      int pb [8] = '{7, 8, 9, 1, 6, 11, 13, 15};
      int pv [8] = '{5, 1, 9, 0, 2, 3, 4, 6};
      for (int k = 0; k < 8; k++) begin
         brd_val[pa[k]] = 4'(pv[k]);
         brd_val[pb[k]] = 4'(pv[k]);
      end
   endtask

   task automatic shuffle_board();
      int v [16];
      int j, t, off;
      for (int i = 0; i < 16; i++) v[i] = i / 2;
      for (int i = 15; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = v[i]; v[i] = v[j]; v[j] = t;
      end
      off = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) brd_val[i] = 4'(v[i] ^ off);
   endtask

   // Idle in PICK1/PICK2 until the forfeit pulse; the turn may idle TURN_TIMEOUT cycles.
   task automatic expect_idle_timeout(input string tag);
      int n = 0;
      while (!bus.timeout && n < TURN_TIMEOUT + 100) begin
         step();
         n++;
      end
      check({tag, "_cycles"}, n, TURN_TIMEOUT);
      exp_player ^= 1;
      check({tag, "_player"}, int'(bus.player), exp_player);
      check({tag, "_reveal_en"}, int'(bus.reveal_en), 0);
   endtask

   task automatic play_pair(input int a, input int b, input int junk);
      int m, n, c;
      pick(a);
      check("pick_a_timeout", int'(bus.timeout), 0);
      check("pick_a_reveal_en", int'(bus.reveal_en), 1);
      check("pick_a_idx", int'(bus.reveal_a), a);
      if (junk != 0) begin
         pick(a);
         check("dup_ignored", int'(bus.reveal_en), 1);
         c = -1;
         for (int i = 0; i < 16; i++) if (!brd_av[i] && c < 0) c = i;
         if (c >= 0) begin
            pick(c);
            check("cleared_ignored", int'(bus.reveal_en), 1);
         end
         check("junk_keeps_a", int'(bus.reveal_a), a);
      end
      pick(b);
      m = (brd_val[a] == brd_val[b]) ? 1 : 0;
      check("pick_b_reveal_en", int'(bus.reveal_en), 3);
      check("pick_b_idx", int'(bus.reveal_b), b);
      check("match_pulse", int'(bus.match), m);
      if (m != 0) begin
         if (exp_s[exp_player] < 255) exp_s[exp_player]++;
         pairs_left--;
         step();
         check("clear1_we", int'(bus.clear_we), 1);
         check("clear1_idx", int'(bus.clear_idx), a);
         check("match_width", int'(bus.match), 0);
         check("score0", int'(bus.score0), exp_s[0]);
         check("score1", int'(bus.score1), exp_s[1]);
         step();
         check("clear2_we", int'(bus.clear_we), 1);
         check("clear2_idx", int'(bus.clear_idx), b);
         step();
         check("after_clear_we", int'(bus.clear_we), 0);
         check("after_clear_reveal", int'(bus.reveal_en), 0);
         check("bonus_player", int'(bus.player), exp_player);
         check("game_over", int'(bus.game_over), (pairs_left == 0) ? 1 : 0);
         if (pairs_left == 0) check("winner", int'(bus.winner), exp_winner());
         brd_av[a] = 1'b0;
         brd_av[b] = 1'b0;
      end else begin
         n = 0;
         step();
         while (bus.reveal_en == 2'b11 && n < SHOW_CYCLES + 20) begin
            n++;
            step();
         end
         check("show_cycles", n, SHOW_CYCLES);
         exp_player ^= 1;
         check("show_player", int'(bus.player), exp_player);
         check("show_score0", int'(bus.score0), exp_s[0]);
         check("show_score1", int'(bus.score1), exp_s[1]);
      end
   endtask

   initial begin
      int cnt;
      int a, b, partner, turns;
      int avl [$];
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.select  = 1'b0;
      bus.sel_idx = 4'd0;
      set_directed_board();
      new_game_model();
      step(); step();
      rst = 1'b0;
      step();
      check_fresh("reset");
      check("reset_match", int'(bus.match), 0);
      check("reset_timeout", int'(bus.timeout), 0);

      // reset while a mismatched pair is on display
      start_game();
      pick(3);
      pick(4);
      repeat (10) step();
      check("in_show_reveal", int'(bus.reveal_en), 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_fresh("mid_show_rst");
      pick(2);
      check("idle_select_ignored", int'(bus.reveal_en), 0);

      // start and select together in IDLE: only the start takes effect
      bus.start   = 1'b1;
      bus.select  = 1'b1;
      bus.sel_idx = 4'd2;
      step();
      bus.start  = 1'b0;
      bus.select = 1'b0;
      new_game_model();
      check("start_with_select", int'(bus.reveal_en), 0);

      play_pair(2, 7, 0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("start_midgame_ignored", int'(bus.score0), 1);
      play_pair(3, 4, 0);
      play_pair(3, 8, 1);
      expect_idle_timeout("pick1_timeout");
      cnt = 0;
      repeat (TURN_TIMEOUT - 1) begin
         step();
         if (bus.timeout) cnt++;
      end
      check("timeout_one_cycle", cnt, 0);
      play_pair(9, 4, 0);
      play_pair(0, 1, 0);
      play_pair(5, 6, 0);
      play_pair(10, 11, 0);
      play_pair(12, 14, 0);
      play_pair(12, 13, 0);
      play_pair(14, 15, 0);
      repeat (5) step();
      check("done_held", int'(bus.game_over), 1);
      check("done_winner_p0", int'(bus.winner), 1);

      // tie game, including a forfeit with one card already picked
      start_game();
      play_pair(2, 7, 0);
      play_pair(3, 8, 0);
      play_pair(4, 9, 0);
      play_pair(0, 1, 0);
      pick(5);
      check("pick2_entry", int'(bus.reveal_en), 1);
      expect_idle_timeout("pick2_timeout");
      play_pair(5, 6, 0);
      play_pair(10, 11, 0);
      play_pair(12, 13, 0);
      play_pair(14, 15, 0);
      check("tie_winner", int'(bus.winner), 3);

      for (int g = 0; g < 3; g++) begin
         shuffle_board();
         start_game();
         turns = 0;
         while (pairs_left > 0 && turns < 200) begin
            avl.delete();
            for (int i = 0; i < 16; i++) if (brd_av[i]) avl.push_back(i);
            a = avl[$urandom_range(0, avl.size() - 1)];
            partner = a;
            for (int i = 0; i < 16; i++)
               if (i != a && brd_av[i] && brd_val[i] == brd_val[a]) partner = i;
            if ($urandom_range(0, 1) == 1) begin
               b = partner;
            end else begin
               b = a;
               while (b == a) b = avl[$urandom_range(0, avl.size() - 1)];
            end
            repeat ($urandom_range(0, 3)) step();
            play_pair(a, b, ($urandom_range(0, 3) == 0) ? 1 : 0);
            turns++;
         end
         check("random_game_over", int'(bus.game_over), 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
